// File: rtl/redmule_castout_ctrl_pkg.sv
`default_nettype none
// redmule_castout_ctrl_pkg: shared types and defaults for the output cast sequencer.
package redmule_castout_ctrl_pkg;

  localparam int unsigned DATA_W   = 288;
  localparam int unsigned CAST_LAT = 1;

  // Encoding matches the FP format enumeration used by the cast datapath.
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4,
    FP8ALT  = 3'd5
  } fp_format_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } castout_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/redmule_castout_ctrl_fifo.sv
`default_nettype none
// redmule_castout_ctrl_fifo: registered-head output FIFO; push and pop on a
// full FIFO in the same cycle is supported.
module redmule_castout_ctrl_fifo #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 2,
  parameter int unsigned OccW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [DataW-1:0] wdata,
  input  logic             pop,
  output logic [DataW-1:0] rdata,
  output logic             empty,
  output logic [OccW-1:0]  usage
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataW-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      usage <= usage + OccW'(push) - OccW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (usage == '0);

endmodule
`default_nettype wire

// File: rtl/redmule_castout_ctrl.sv
`default_nettype none
// redmule_castout_ctrl: streams Z words through the cast datapath into a
// credit-protected output FIFO and pulses done when the job has drained.
module redmule_castout_ctrl
  import redmule_castout_ctrl_pkg::*;
#(
  parameter int unsigned DataW     = DATA_W,
  parameter int unsigned CastLat   = CAST_LAT,
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned CntW      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CntW-1:0]  cfg_n_words_i,
  input  logic             cfg_cast_i,
  input  fp_format_e       cfg_dst_fmt_i,
  input  logic             in_valid_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             in_ready_o,
  output logic [DataW-1:0] cast_src_o,
  output logic             cast_en_o,
  output fp_format_e       cast_dst_fmt_o,
  input  logic [DataW-1:0] cast_res_i,
  output logic             out_valid_o,
  output logic [DataW-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o
);
  localparam int unsigned OccW  = $clog2(FifoDepth + 1);
  localparam int unsigned CredW = $clog2(FifoDepth + CastLat + 1) + 1;

  castout_ctrl_state_e state;
  logic [CntW-1:0]     n_words;
  logic [CntW-1:0]     issued;
  logic                soft_rst;
  logic                accept;
  logic                pop;
  logic                push;
  logic                fifo_empty;
  logic [OccW-1:0]     occ;
  logic [CredW-1:0]    inflight;
  logic [CredW-1:0]    credit;

  assign soft_rst   = !rst_ni || clear_i;
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = out_valid_o && out_ready_i;
  assign cast_src_o = in_data_i;

  // Words that will occupy pipeline + FIFO after this cycle's pop; a new
  // accept is only allowed if it still fits into the FIFO eventually.
  assign credit     = inflight + CredW'(occ) - CredW'(pop);
  assign in_ready_o = (state == RUN) && (issued < n_words) &&
                      (credit < CredW'(FifoDepth));

  if (CastLat > 0) begin : g_pipe
    logic [CastLat-1:0] vld;

    always_ff @(posedge clk_i) begin
      if (soft_rst) vld <= '0;
      else          vld <= (vld << 1) | CastLat'(accept);
    end

    always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(CastLat); i++) inflight = inflight + CredW'(vld[i]);
    end

    assign push = vld[CastLat-1];
  end else begin : g_comb
    assign inflight = '0;
    assign push     = accept;
  end

  redmule_castout_ctrl_fifo #(
    .DataW (DataW),
    .Depth (FifoDepth),
    .OccW  (OccW)
  ) i_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (clear_i),
    .push  (push),
    .wdata (cast_res_i),
    .pop   (pop),
    .rdata (out_data_o),
    .empty (fifo_empty),
    .usage (occ)
  );

  assign out_valid_o = !fifo_empty;
  assign busy_o      = (state != IDLE);
  assign cfg_ready_o = (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state          <= IDLE;
      n_words        <= '0;
      issued         <= '0;
      done_o         <= 1'b0;
      cast_en_o      <= 1'b0;
      cast_dst_fmt_o <= FP16;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid_i) begin
            n_words        <= cfg_n_words_i;
            cast_en_o      <= cfg_cast_i;
            cast_dst_fmt_o <= cfg_dst_fmt_i;
            issued         <= '0;
            if (cfg_n_words_i == '0) done_o <= 1'b1;
            else                     state  <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            issued <= issued + CntW'(1);
            if (issued + CntW'(1) == n_words) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (credit == '0) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_redmule_castout_ctrl.sv
`default_nettype none
// tb_redmule_castout_ctrl: directed jobs with a queue-based scoreboard and a
// behavioural CastLat-deep cast datapath (cast = bitwise invert, bypass = copy).
module tb_redmule_castout_ctrl;
  import redmule_castout_ctrl_pkg::*;

  localparam int unsigned DataW     = 288;
  localparam int unsigned CastLat   = 1;
  localparam int unsigned FifoDepth = 2;
  localparam int unsigned CntW      = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CntW-1:0]  cfg_n;
  logic             cfg_cast;
  fp_format_e       cfg_fmt;
  logic             in_valid;
  logic [DataW-1:0] in_data;
  logic             in_ready;
  logic [DataW-1:0] cast_src;
  logic             cast_en;
  fp_format_e       cast_fmt;
  logic [DataW-1:0] cast_res;
  logic             out_valid;
  logic [DataW-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int accepted = 0;
  bit lat_chk = 0;
  logic [DataW-1:0] exp_q[$];
  int               acc_q[$];

  always #5 clk = ~clk;

  redmule_castout_ctrl #(
    .DataW(DataW), .CastLat(CastLat), .FifoDepth(FifoDepth), .CntW(CntW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_n_words_i(cfg_n),
    .cfg_cast_i(cfg_cast), .cfg_dst_fmt_i(cfg_fmt),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .cast_src_o(cast_src), .cast_en_o(cast_en), .cast_dst_fmt_o(cast_fmt),
    .cast_res_i(cast_res),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done)
  );

  // Behavioural cast datapath with one pipeline stage.
  logic [DataW-1:0] dp_q;
  always_ff @(posedge clk) dp_q <= cast_en ? ~cast_src : cast_src;
  assign cast_res = dp_q;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [DataW-1:0] act, input logic [DataW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Scoreboard monitor: compares every popped output and checks head stability.
  initial begin
    bit               stalled = 0;
    logic [DataW-1:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst_n && !clear) begin
        if (done) done_cnt++;
        if (out_valid) begin
          if (stalled) chk("stall_hold", out_data, held);
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out: got %0h, required no output", out_data);
            end else begin
              logic [DataW-1:0] e;
              int a;
              e = exp_q.pop_front();
              a = acc_q.pop_front();
              chk("out_data", out_data, e);
              if (lat_chk) chk("latency", DataW'(cyc - a), DataW'(CastLat + 1));
            end
            stalled = 0;
          end else begin
            stalled = 1;
            held    = out_data;
          end
        end else begin
          stalled = 0;
        end
      end
    end
  end

  task automatic do_cfg(input logic [CntW-1:0] n, input logic cast, input fp_format_e fmt);
    int g = 0;
    cfg_valid = 1'b1;
    cfg_n     = n;
    cfg_cast  = cast;
    cfg_fmt   = fmt;
    @(negedge clk);
    while (!cfg_ready && g < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      g++;
    end
    if (g >= 50) timeout("cfg_handshake");
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic cast, input logic [DataW-1:0] base, output int cycles);
    int i = 0;
    cycles = 0;
    while (i < n && cycles < 200) begin
      logic [DataW-1:0] w;
      w        = base + DataW'(i);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(cast ? ~w : w);
        acc_q.push_back(cyc);
        accepted++;
        i++;
      end
      cycles++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (i < n) timeout("feed");
  endtask

  task automatic wait_done(input int budget);
    int g = 0;
    @(negedge clk);
    while (!done && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (!done) begin
      timeout("done_wait");
    end else begin
      chk("busy_at_done", DataW'(busy), DataW'(0));
      chk("scoreboard_empty", DataW'(exp_q.size()), DataW'(0));
      @(negedge clk);
      chk("done_one_cycle", DataW'(done), DataW'(0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int cycles;
    int d0;
    #200000;
    $display("FAIL watchdog: simulation did not terminate, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int d0;
    rst_n = 1'b0; clear = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_cast = 1'b0;
    cfg_fmt = FP32; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", DataW'(out_valid), DataW'(0));
    chk("rst_done", DataW'(done), DataW'(0));
    chk("rst_busy", DataW'(busy), DataW'(0));
    chk("rst_cfg_ready", DataW'(cfg_ready), DataW'(1));
    chk("rst_in_ready", DataW'(in_ready), DataW'(0));
    chk("rst_cast_en", DataW'(cast_en), DataW'(0));
    chk("rst_fmt", DataW'(cast_fmt), DataW'(FP16));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Job 1: n=4 narrow cast, no backpressure.
    lat_chk = 1;
    do_cfg(16'd4, 1'b1, FP8);
    @(negedge clk);
    chk("job1_busy", DataW'(busy), DataW'(1));
    chk("job1_cfg_ready", DataW'(cfg_ready), DataW'(0));
    chk("job1_cast_en", DataW'(cast_en), DataW'(1));
    chk("job1_fmt", DataW'(cast_fmt), DataW'(FP8));
    @(posedge clk); #1;
    d0 = done_cnt;
    feed(4, 1'b1, 288'h1000, cycles);
    chk("job1_consecutive", DataW'(cycles), DataW'(4));
    wait_done(20);
    chk("job1_done_count", DataW'(done_cnt - d0), DataW'(1));
    lat_chk = 0;

    // Job 2: n=6 with 10 stalled cycles on the output.
    out_ready = 1'b0;
    accepted  = 0;
    do_cfg(16'd6, 1'b1, FP16);
    fork
      feed(6, 1'b1, 288'hA5A5_0000, cycles);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("bp_credit_limit", DataW'(accepted), DataW'(FifoDepth));
        out_ready = 1'b1;
      end
    join
    wait_done(30);

    // Job 3: n=0 completes immediately without going busy.
    d0 = done_cnt;
    do_cfg(16'd0, 1'b1, FP8);
    @(negedge clk);
    chk("n0_done", DataW'(done), DataW'(1));
    chk("n0_busy", DataW'(busy), DataW'(0));
    chk("n0_in_ready", DataW'(in_ready), DataW'(0));
    @(negedge clk);
    chk("n0_done_pulse", DataW'(done), DataW'(0));
    chk("n0_done_count", DataW'(done_cnt - d0), DataW'(1));
    @(posedge clk); #1;

    // Job 4: bypass keeps data bit-exact.
    do_cfg(16'd3, 1'b0, FP16);
    @(negedge clk);
    chk("bypass_cast_en", DataW'(cast_en), DataW'(0));
    @(posedge clk); #1;
    feed(3, 1'b0, {18{16'h3C00}}, cycles);
    wait_done(20);

    // Job 5: clear with two words held, then a fresh n=1 job.
    out_ready = 1'b0;
    do_cfg(16'd4, 1'b1, FP8);
    feed(2, 1'b1, 288'hBEEF_0000, cycles);
    d0 = done_cnt;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("clr_out_valid", DataW'(out_valid), DataW'(0));
    chk("clr_busy", DataW'(busy), DataW'(0));
    chk("clr_cfg_ready", DataW'(cfg_ready), DataW'(1));
    chk("clr_fmt", DataW'(cast_fmt), DataW'(FP16));
    repeat (3) @(negedge clk);
    chk("clr_no_done", DataW'(done_cnt - d0), DataW'(0));
    chk("clr_out_valid_late", DataW'(out_valid), DataW'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_cfg(16'd1, 1'b1, FP8);
    feed(1, 1'b1, 288'h77, cycles);
    wait_done(20);

    // Job 6: a config pulse mid-job must be ignored.
    do_cfg(16'd3, 1'b1, FP16);
    fork
      feed(3, 1'b1, 288'hC0DE_0000, cycles);
      begin
        cfg_valid = 1'b1;
        cfg_n     = 16'd7;
        cfg_cast  = 1'b0;
        cfg_fmt   = FP32;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("ign_fmt", DataW'(cast_fmt), DataW'(FP16));
        chk("ign_cast_en", DataW'(cast_en), DataW'(1));
      end
    join
    wait_done(20);
    chk("ign_fmt_end", DataW'(cast_fmt), DataW'(FP16));
    chk("ign_idle_after", DataW'(busy), DataW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
